// File: rtl/match_clock_ctrl.sv
// Scoreboard game-clock controller: period countdown, shot clock, period sequencing,
// speed modes, buzzer and low-time warning.
module match_clock_ctrl #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TIME_W      = 12,
    parameter int unsigned PERIOD_SEC  = 600,
    parameter int unsigned MAX_SEC     = 3599,
    parameter int unsigned NUM_PERIODS = 4,
    parameter int unsigned SHOT_SEC    = 24,
    parameter int unsigned WARN_SEC    = 30,
    parameter int unsigned BUZZ_CYC    = 25_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_set_en,
    input  logic              i_add_sub,
    input  logic              i_inc_sec,
    input  logic              i_inc_min,
    input  logic              i_shot_rst,
    input  logic [1:0]        i_speed,
    output logic [TIME_W-1:0] o_game_sec,
    output logic [5:0]        o_shot_sec,
    output logic [2:0]        o_period,
    output logic [2:0]        o_state,
    output logic              o_period_end,
    output logic              o_shot_viol,
    output logic              o_warn_led,
    output logic              o_buzzer
);

    localparam int unsigned PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BUZZ_W = $clog2(BUZZ_CYC + 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StPause = 3'd2,
        StSet   = 3'd3,
        StPend  = 3'd4,
        StOver  = 3'd5
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [TIME_W-1:0]   r_game, w_game_nxt;
    logic [5:0]          r_shot, w_shot_nxt;
    logic [2:0]          r_period, w_period_nxt;
    logic [PRE_W-1:0]    r_pre, w_pre_nxt;
    logic [BUZZ_W-1:0]   r_buzz_cnt, w_buzz_nxt;
    logic                r_start_q;
    logic                r_period_end, w_period_end_nxt;
    logic                r_shot_viol, w_shot_viol_nxt;

    logic                w_tick, w_start_rise;
    logic [3:0]          w_step;
    logic [TIME_W:0]     w_game_ext, w_step_g, w_delta, w_sum;
    logic [TIME_W-1:0]   w_game_dec, w_game_set;
    logic [5:0]          w_shot_dec;
    logic                w_game_hit0, w_shot_hit0;

    assign w_tick       = (r_state == StRun) && (r_pre == PRE_W'(CLK_HZ - 1));
    assign w_start_rise = i_start && !r_start_q;

    always_comb begin
        unique case (i_speed)
            2'b10:   w_step = 4'd5;
            2'b11:   w_step = 4'd10;
            default: w_step = 4'd1;
        endcase
    end

    // All game-time arithmetic is done one bit wider so no compare can wrap.
    assign w_game_ext  = {1'b0, r_game};
    assign w_step_g    = (TIME_W + 1)'(w_step);
    assign w_game_hit0 = w_tick && (r_game != '0) && (w_game_ext <= w_step_g);
    assign w_game_dec  = (w_game_ext <= w_step_g) ? '0 : r_game - TIME_W'(w_step);
    assign w_shot_hit0 = w_tick && (r_shot != '0) && (r_shot <= 6'(w_step));
    assign w_shot_dec  = (r_shot <= 6'(w_step)) ? '0 : r_shot - 6'(w_step);

    assign w_delta = (i_inc_min ? (TIME_W + 1)'(60) : '0) + (i_inc_sec ? (TIME_W + 1)'(1) : '0);
    assign w_sum   = w_game_ext + w_delta;

    always_comb begin
        w_game_set = r_game;
        if (i_add_sub) begin
            w_game_set = (w_sum > (TIME_W + 1)'(MAX_SEC)) ? '0 : w_sum[TIME_W-1:0];
        end else begin
            w_game_set = (w_game_ext < w_delta) ? '0 : r_game - w_delta[TIME_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_game_nxt       = r_game;
        w_shot_nxt       = r_shot;
        w_period_nxt     = r_period;
        w_period_end_nxt = 1'b0;
        w_shot_viol_nxt  = 1'b0;
        w_pre_nxt        = '0;
        w_buzz_nxt       = (r_buzz_cnt != '0) ? r_buzz_cnt - 1'b1 : r_buzz_cnt;
        if (r_period_end || r_shot_viol) begin
            w_buzz_nxt = BUZZ_W'(BUZZ_CYC);
        end

        unique case (r_state)
            StIdle, StPause: begin
                if (i_set_en) begin
                    w_state_nxt = StSet;
                end else if (i_start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
                if (w_tick) begin
                    w_game_nxt       = w_game_dec;
                    w_shot_nxt       = w_shot_dec;
                    w_period_end_nxt = w_game_hit0;
                    // A same-cycle shot-clock reload cancels the violation.
                    w_shot_viol_nxt  = w_shot_hit0 && !i_shot_rst;
                end
                if (w_game_hit0) begin
                    w_state_nxt = StPend;
                end else if ((w_shot_hit0 && !i_shot_rst) || !i_start) begin
                    w_state_nxt = StPause;
                end
            end
            StSet: begin
                if (i_inc_min || i_inc_sec) begin
                    w_game_nxt = w_game_set;
                end
                if (!i_set_en) begin
                    w_state_nxt = StPause;
                end
            end
            StPend: begin
                if (w_start_rise) begin
                    w_buzz_nxt = '0;
                    if (r_period < 3'(NUM_PERIODS)) begin
                        w_period_nxt = r_period + 3'd1;
                        w_game_nxt   = TIME_W'(PERIOD_SEC);
                        w_shot_nxt   = 6'(SHOT_SEC);
                        w_state_nxt  = StRun;
                    end else begin
                        w_state_nxt = StOver;
                    end
                end
            end
            StOver: begin
                w_state_nxt = StOver;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        if (i_shot_rst && (r_state != StOver)) begin
            w_shot_nxt = 6'(SHOT_SEC);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_game       <= TIME_W'(PERIOD_SEC);
            r_shot       <= 6'(SHOT_SEC);
            r_period     <= 3'd1;
            r_pre        <= '0;
            r_buzz_cnt   <= '0;
            r_start_q    <= 1'b0;
            r_period_end <= 1'b0;
            r_shot_viol  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_game       <= w_game_nxt;
            r_shot       <= w_shot_nxt;
            r_period     <= w_period_nxt;
            r_pre        <= w_pre_nxt;
            r_buzz_cnt   <= w_buzz_nxt;
            r_start_q    <= i_start;
            r_period_end <= w_period_end_nxt;
            r_shot_viol  <= w_shot_viol_nxt;
        end
    end

    assign o_game_sec   = r_game;
    assign o_shot_sec   = r_shot;
    assign o_period     = r_period;
    assign o_state      = r_state;
    assign o_period_end = r_period_end;
    assign o_shot_viol  = r_shot_viol;
    assign o_buzzer     = (r_buzz_cnt != '0);
    assign o_warn_led   = ((r_state == StRun) && (r_game <= TIME_W'(WARN_SEC))) ? r_game[0] : 1'b0;

endmodule

// File: tb/tb_match_clock_ctrl.sv
// Directed bench for match_clock_ctrl with a 20-cycle second and short periods.
module tb_match_clock_ctrl;

    localparam int unsigned TIME_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, set_en, add_sub, inc_sec, inc_min, shot_rst;
    logic [1:0]        speed;
    logic [TIME_W-1:0] game_sec;
    logic [5:0]        shot_sec;
    logic [2:0]        period, state;
    logic              period_end, shot_viol, warn_led, buzzer;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    match_clock_ctrl #(
        .CLK_HZ(20), .TIME_W(TIME_W), .PERIOD_SEC(10), .MAX_SEC(3599),
        .NUM_PERIODS(2), .SHOT_SEC(4), .WARN_SEC(3), .BUZZ_CYC(3)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_set_en(set_en),
        .i_add_sub(add_sub), .i_inc_sec(inc_sec), .i_inc_min(inc_min),
        .i_shot_rst(shot_rst), .i_speed(speed), .o_game_sec(game_sec),
        .o_shot_sec(shot_sec), .o_period(period), .o_state(state),
        .o_period_end(period_end), .o_shot_viol(shot_viol),
        .o_warn_led(warn_led), .o_buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic add, input logic mn, input logic sc);
        add_sub = add;
        inc_min = mn;
        inc_sec = sc;
        step(1);
        inc_min = 1'b0;
        inc_sec = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_game"}, int'(game_sec), 10);
        check({tag, "_shot"}, int'(shot_sec), 4);
        check({tag, "_period"}, int'(period), 1);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_pend"}, int'(period_end), 0);
        check({tag, "_viol"}, int'(shot_viol), 0);
        check({tag, "_warn"}, int'(warn_led), 0);
        check({tag, "_buzz"}, int'(buzzer), 0);
    endtask

    initial begin
        int buzz_hi;
        rst_n = 1'b0; start = 1'b0; set_en = 1'b0; add_sub = 1'b0;
        inc_sec = 1'b0; inc_min = 1'b0; shot_rst = 1'b0; speed = 2'b00;
        step(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Run at x1 until the shot clock expires after four ticks.
        start = 1'b1;
        step(1);
        check("run_enter", int'(state), 1);
        step(19);
        check("pre_tick_game", int'(game_sec), 10);
        step(1);
        check("tick1_game", int'(game_sec), 9);
        check("tick1_shot", int'(shot_sec), 3);
        step(60);
        check("tick4_game", int'(game_sec), 6);
        check("tick4_shot", int'(shot_sec), 0);
        check("tick4_viol", int'(shot_viol), 1);
        check("tick4_pend", int'(period_end), 0);
        check("tick4_state", int'(state), 2);
        start = 1'b0;
        step(1);
        check("viol_one_cycle", int'(shot_viol), 0);
        buzz_hi = int'(buzzer);
        for (int i = 0; i < 5; i++) begin
            step(1);
            buzz_hi += int'(buzzer);
        end
        check("buzz_len", buzz_hi, 3);

        // Set mode arithmetic.
        set_en = 1'b1;
        step(1);
        check("set_state", int'(state), 3);
        for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b1);
        check("set_to10", int'(game_sec), 10);
        pulse(1'b1, 1'b1, 1'b1);
        check("add_61", int'(game_sec), 71);
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) pulse(1'b1, 1'b0, 1'b1);
        check("set_to30", int'(game_sec), 30);
        pulse(1'b0, 1'b1, 1'b0);
        check("sub_sat", int'(game_sec), 0);
        for (int i = 0; i < 59; i++) pulse(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0, 1'b1);
        check("set_max", int'(game_sec), 3599);
        pulse(1'b1, 1'b0, 1'b1);
        check("add_wrap", int'(game_sec), 0);
        for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, 1'b1);
        shot_rst = 1'b1;
        step(1);
        shot_rst = 1'b0;
        check("shot_rst_set", int'(shot_sec), 4);

        // x10 run from 7 with shot_rst on the tick: period end, no shot violation.
        set_en = 1'b0;
        speed = 2'b11;
        step(1);
        check("set_exit", int'(state), 2);
        start = 1'b1;
        step(1);
        step(19);
        shot_rst = 1'b1;
        step(1);
        shot_rst = 1'b0;
        check("x10_game", int'(game_sec), 0);
        check("x10_pend", int'(period_end), 1);
        check("x10_state", int'(state), 4);
        check("x10_shot", int'(shot_sec), 4);
        check("x10_noviol", int'(shot_viol), 0);
        step(1);
        check("pend_buzz", int'(buzzer), 1);
        check("pend_hold", int'(state), 4);

        // Next period on start rising edge.
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        check("p2_period", int'(period), 2);
        check("p2_game", int'(game_sec), 10);
        check("p2_state", int'(state), 1);
        check("p2_buzz_clr", int'(buzzer), 0);
        step(20);
        check("p2_end_game", int'(game_sec), 0);
        check("p2_both_pend", int'(period_end), 1);
        check("p2_both_viol", int'(shot_viol), 1);
        check("p2_both_state", int'(state), 4);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        check("over_state", int'(state), 5);
        check("over_period", int'(period), 2);
        set_en = 1'b1;
        shot_rst = 1'b1;
        step(2);
        set_en = 1'b0;
        shot_rst = 1'b0;
        check("over_hold", int'(state), 5);
        check("over_shot", int'(shot_sec), 0);

        // Low-time warning.
        start = 1'b0;
        speed = 2'b00;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        set_en = 1'b1;
        step(1);
        for (int i = 0; i < 7; i++) pulse(1'b0, 1'b0, 1'b1);
        check("warn_set3", int'(game_sec), 3);
        set_en = 1'b0;
        step(1);
        check("warn_paused", int'(warn_led), 0);
        start = 1'b1;
        step(1);
        check("warn_at3", int'(warn_led), 1);
        step(20);
        check("warn_game2", int'(game_sec), 2);
        check("warn_at2", int'(warn_led), 0);
        step(20);
        check("warn_at1", int'(warn_led), 1);
        start = 1'b0;
        step(1);
        check("warn_pause", int'(warn_led), 0);

        // Reset mid-RUN with buzzer active; speed 01 is x1.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        speed = 2'b01;
        start = 1'b1;
        step(1);
        step(80);
        check("s01_game", int'(game_sec), 6);
        check("s01_viol", int'(shot_viol), 1);
        step(1);
        check("rerun_state", int'(state), 1);
        check("rerun_buzz", int'(buzzer), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #1;
        rst_n = 1'b1;

        // x5 run: one tick.
        speed = 2'b10;
        step(1);
        step(20);
        check("x5_game", int'(game_sec), 5);
        check("x5_shot", int'(shot_sec), 0);
        check("x5_state", int'(state), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
